// File: rtl/pmp_cfg_regs_if.sv
// Valid/ready register port between a host (master) and the PMP configuration register file (slave).
interface pmp_cfg_regs_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [6:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
    );
endinterface

// File: rtl/pmp_cfg_regs.sv
// IO-PMP configuration register file: pmpcfg/pmpaddr storage with lock and WARL legalisation,
// driving the combinational PMP checker directly from the stored state.
module pmp_cfg_regs #(
    parameter int unsigned PMP_LEN        = 32,
    parameter int unsigned NR_ENTRIES     = 4,
    parameter int unsigned PMPGranularity = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    pmp_cfg_regs_if.slave             bus,
    output logic [15:0][7:0]          conf_o,
    output logic [15:0][PMP_LEN-1:0]  conf_addr_o,
    output logic                      cfg_update_o
);
    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    localparam logic [16:0] IMPL_W  = (17'd1 << NR_ENTRIES) - 17'd1;
    localparam logic [15:0] IMPL    = IMPL_W[15:0];
    localparam logic [31:0] GMASK_W = (PMPGranularity >= 1) ? ((32'd1 << PMPGranularity) - 32'd1) : 32'd0;
    localparam logic [31:0] NMASK_W = (PMPGranularity >= 2) ? ((32'd1 << (PMPGranularity - 1)) - 32'd1) : 32'd0;
    localparam logic [PMP_LEN-1:0] GMASK = GMASK_W[PMP_LEN-1:0];
    localparam logic [PMP_LEN-1:0] NMASK = NMASK_W[PMP_LEN-1:0];

    logic [15:0][7:0]         cfg_q, cfg_d;
    logic [15:0][PMP_LEN-1:0] addr_q, addr_d;
    logic                     rsp_valid_q, rsp_error_q, upd_q;
    logic [31:0]              rsp_rdata_q;

    logic                     accept, cfg_hit, addr_hit, dec_err, tor_lock;
    logic [1:0]               cfg_word;
    logic [3:0]               addr_idx, ent;
    logic [31:0]              merged, rd_val;
    logic [PMP_LEN-1:0]       rd_addr;
    logic [1:0]               rd_a;

    assign bus.req_ready_o = !rsp_valid_q || bus.rsp_ready_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;

    assign cfg_hit  = (bus.req_addr_i[1:0] == 2'b00) && (bus.req_addr_i[6:4] == 3'b000);
    assign addr_hit = (bus.req_addr_i[1:0] == 2'b00) && bus.req_addr_i[6];
    assign dec_err  = !(cfg_hit || addr_hit);
    assign cfg_word = bus.req_addr_i[3:2];
    assign addr_idx = bus.req_addr_i[5:2];

    function automatic logic [7:0] legal_cfg(input logic [7:0] b);
        logic [7:0] r;
        r      = b;
        r[6:5] = 2'b00;
        if (!r[0] && r[1]) r[1] = 1'b0;
        if ((PMPGranularity >= 1) && (r[4:3] == A_NA4)) r[4:3] = A_OFF;
        return r;
    endfunction

    // All lock checks look at cfg_q, so a lock set by this write only affects later requests.
    always_comb begin
        cfg_d    = cfg_q;
        addr_d   = addr_q;
        ent      = '0;
        merged   = 32'(addr_q[addr_idx]);
        tor_lock = (addr_idx != 4'hF) && cfg_q[addr_idx + 4'd1][7] &&
                   (cfg_q[addr_idx + 4'd1][4:3] == A_TOR);
        for (int k = 0; k < 4; k++) begin
            ent = {cfg_word, 2'(k)};
            if (accept && bus.req_we_i && cfg_hit && bus.req_wstrb_i[k] && IMPL[ent] && !cfg_q[ent][7])
                cfg_d[ent] = legal_cfg(bus.req_wdata_i[8*k +: 8]);
        end
        for (int b = 0; b < 4; b++) begin
            if (bus.req_wstrb_i[b]) merged[8*b +: 8] = bus.req_wdata_i[8*b +: 8];
        end
        if (accept && bus.req_we_i && addr_hit && IMPL[addr_idx] && !cfg_q[addr_idx][7] && !tor_lock)
            addr_d[addr_idx] = merged[PMP_LEN-1:0] & ~GMASK;
    end

    always_comb begin
        rd_val  = '0;
        rd_a    = cfg_q[addr_idx][4:3];
        rd_addr = addr_q[addr_idx];
        if (rd_a == A_NAPOT) rd_addr = rd_addr | NMASK;
        if (rd_a == A_OFF || rd_a == A_TOR) rd_addr = rd_addr & ~GMASK;
        if (cfg_hit)
            rd_val = {cfg_q[{cfg_word, 2'd3}], cfg_q[{cfg_word, 2'd2}],
                      cfg_q[{cfg_word, 2'd1}], cfg_q[{cfg_word, 2'd0}]};
        else if (addr_hit)
            rd_val = 32'(rd_addr);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cfg_q       <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            upd_q       <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            addr_q <= addr_d;
            upd_q  <= (cfg_d != cfg_q) || (addr_d != addr_q);
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= bus.req_we_i ? 32'd0 : rd_val;
                rsp_error_q <= dec_err;
            end else if (bus.rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_error_o = rsp_error_q;
    assign conf_o          = cfg_q;
    assign conf_addr_o     = addr_q;
    assign cfg_update_o    = upd_q;
endmodule
